fht_control: RTL and testbench

- Address and sequencing controller for an in-place, ping-pong, 4-bank Fast Hartley Transform of N = 4·2^A_BIT points.
- On a start pulse it walks stage 0 (bit-reversed read, 4-point butterflies across the four banks) and then stages 1..A_BIT (radix-2 FHT butterflies within each bank).
- Per stage it generates read, write, bias (mirror) and coefficient addresses, RAM write enables, and source selects for the butterfly datapath.
- It raises oRDY when the transform is complete.

---
 rtl/fht_pkg.sv | 33 +++
 rtl/fht_control_if.sv | 44 ++++
 rtl/fht_delay_line.sv | 26 ++
 rtl/fht_control.sv | 147 ++++++++++++++
 tb/tb_fht_control.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fht_pkg.sv
// Shared definitions for the FHT address/sequencing controller:
// default geometry, derived sizes and the bit-reverse helper used by stage 0.
package fht_pkg;

  localparam int A_BIT_DEF = 6;
  localparam int LAT_DEF   = 4;
  localparam int D_DEF     = 1 << A_BIT_DEF;
  localparam int N_STAGES_DEF = A_BIT_DEF + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fht_state_e;

  function automatic int bank_depth(input int a_bit);
    return 1 << a_bit;
  endfunction

  function automatic int stage_width(input int a_bit);
    return $clog2(a_bit + 1);
  endfunction

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[w-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_control_if.sv
// Sequencing/address bundle between the FHT controller and the bank RAMs,
// butterfly datapath and the host that launches a transform.
interface fht_control_if
  import fht_pkg::*;
#(
  parameter int A_BIT = A_BIT_DEF
) ();

  logic             iSTART;
  logic             oST_ZERO;
  logic             oST_LAST;
  logic             o2ND_PART_SUBSEC;
  logic [A_BIT-1:0] oSECTOR;
  logic [A_BIT-1:0] oADDR_RD_0;
  logic [A_BIT-1:0] oADDR_RD_1;
  logic [A_BIT-1:0] oADDR_RD_2;
  logic [A_BIT-1:0] oADDR_RD_3;
  logic [A_BIT-1:0] oADDR_WR;
  logic [A_BIT-1:0] oADDR_WR_BIAS;
  logic [A_BIT-1:0] oADDR_COEF;
  logic             oWE_A;
  logic             oWE_B;
  logic             oSOURCE_DATA;
  logic             oSOURCE_CONT;
  logic             oRDY;

  // master: the controller driving addresses; slave: host/datapath side
  modport master (
    input  iSTART,
    output oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    output oADDR_WR, oADDR_WR_BIAS, oADDR_COEF,
    output oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT, oRDY
  );

  modport slave (
    output iSTART,
    input  oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    input  oADDR_WR, oADDR_WR_BIAS, oADDR_COEF,
    input  oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT, oRDY
  );

endinterface

// File: rtl/fht_delay_line.sv
// LAT-deep register shift line; aligns read-side addresses and the read
// strobe with the write side of the butterfly pipeline.
module fht_delay_line #(
  parameter int W   = 1,
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr_p [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) sr_p[i] <= '0;
    end else begin
      sr_p[0] <= din;
      for (int i = 1; i < LAT; i++) sr_p[i] <= sr_p[i-1];
    end
  end

  assign dout = sr_p[LAT-1];

endmodule

// File: rtl/fht_control.sv
// Address and sequencing controller for an in-place ping-pong 4-bank FHT:
// stage 0 bit-reversed 4-point pass, then stages 1..A_BIT of radix-2 butterflies.
module fht_control
  import fht_pkg::*;
#(
  parameter int A_BIT = A_BIT_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic           iCLK,
  input  logic           iRESET,
  fht_control_if.master  bus
);

  localparam int D  = bank_depth(A_BIT);
  localparam int SW = stage_width(A_BIT);

  fht_state_e       state, state_nxt;
  logic [SW-1:0]    stage, stage_nxt;
  logic [A_BIT-1:0] cnt, cnt_nxt;
  logic             EOF_READ, eof_nxt;

  logic             running;
  logic             rd_act;
  logic [A_BIT-1:0] addr_rd;
  logic [A_BIT-1:0] addr_rd_bias;
  logic [A_BIT-1:0] sector;
  logic [A_BIT-1:0] coef;
  logic             part2;
  logic [A_BIT-1:0] mask;
  logic [A_BIT-1:0] hmask;
  logic [A_BIT-1:0] offset;

  logic             we_p;
  logic [A_BIT-1:0] addr_wr_p;
  logic [A_BIT-1:0] bias_wr_p;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state    <= ST_IDLE;
      stage    <= '0;
      cnt      <= '0;
      EOF_READ <= 1'b0;
    end else begin
      state    <= state_nxt;
      stage    <= stage_nxt;
      cnt      <= cnt_nxt;
      EOF_READ <= eof_nxt;
    end
  end

  // cnt is reused during the drain phase to count the LAT flush clocks.
  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    cnt_nxt   = cnt;
    eof_nxt   = EOF_READ;
    case (state)
      ST_IDLE: begin
        if (bus.iSTART) begin
          state_nxt = ST_RUN;
          stage_nxt = '0;
          cnt_nxt   = '0;
          eof_nxt   = 1'b0;
        end
      end
      ST_RUN: begin
        if (!EOF_READ) begin
          if (cnt == A_BIT'(D - 1)) begin
            eof_nxt = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (cnt == A_BIT'(LAT - 1)) begin
          eof_nxt = 1'b0;
          cnt_nxt = '0;
          if (stage == SW'(A_BIT)) state_nxt = ST_IDLE;
          else                     stage_nxt = stage + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign running = (state == ST_RUN);
  assign rd_act  = running && !EOF_READ;

  // Sector of length 2^stage: mask selects the in-sector offset bits,
  // hmask the offset within the half sector.
  always_comb begin
    mask = '0;
    for (int i = 0; i < A_BIT; i++) begin
      if (i < int'(stage)) mask[i] = 1'b1;
    end
    hmask  = mask >> 1;
    offset = cnt & mask;

    addr_rd      = '0;
    addr_rd_bias = '0;
    sector       = '0;
    part2        = 1'b0;
    coef         = '0;
    if (rd_act) begin
      if (stage == '0) begin
        addr_rd      = A_BIT'(bit_reverse(32'(cnt), A_BIT));
        addr_rd_bias = addr_rd;
      end else begin
        addr_rd      = cnt;
        addr_rd_bias = (cnt & ~mask) | ((A_BIT'(0) - offset) & mask);
        sector       = cnt >> stage;
        part2        = |(cnt & mask & ~hmask);
        coef         = (cnt & hmask) << (SW'(A_BIT) - stage);
      end
    end
  end

  // read side -> write side, LAT clocks of butterfly latency
  fht_delay_line #(
    .W   (2 * A_BIT + 1),
    .LAT (LAT)
  ) u_wr_dly (
    .clk  (iCLK),
    .rst  (iRESET),
    .din  ({rd_act, addr_rd, addr_rd_bias}),
    .dout ({we_p, addr_wr_p, bias_wr_p})
  );

  assign bus.oRDY             = !running;
  assign bus.oSOURCE_CONT     = running;
  assign bus.oST_ZERO         = running && (stage == '0);
  assign bus.oST_LAST         = running && (stage == SW'(A_BIT));
  assign bus.oSOURCE_DATA     = running && stage[0];
  assign bus.o2ND_PART_SUBSEC = part2;
  assign bus.oSECTOR          = sector;
  assign bus.oADDR_RD_0       = addr_rd;
  assign bus.oADDR_RD_1       = addr_rd;
  assign bus.oADDR_RD_2       = addr_rd_bias;
  assign bus.oADDR_RD_3       = addr_rd_bias;
  assign bus.oADDR_WR         = addr_wr_p;
  assign bus.oADDR_WR_BIAS    = bias_wr_p;
  assign bus.oADDR_COEF       = coef;
  assign bus.oWE_A            = we_p && running && stage[0];
  assign bus.oWE_B            = we_p && running && !stage[0];

endmodule

// File: tb/tb_fht_control.sv
// Scoreboard bench for fht_control: a per-clock reference of the whole run is
// queued at start and a negedge monitor pops and compares every clock.
module tb_fht_control;
  import fht_pkg::*;

  localparam int AB      = 6;
  localparam int LT      = 4;
  localparam int D       = 1 << AB;
  localparam int SL      = D + LT;
  localparam int RUN_CYC = (AB + 1) * SL;

  typedef struct {
    bit idle;
    int stg;
    bit st_zero, st_last, src_data, we_a, we_b, rd_ph, we;
    int rd, bias, sec, p2, coef, wr, wrb;
  } exp_t;

  logic iCLK = 1'b0;
  logic iRESET = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  fht_control_if #(.A_BIT(AB)) bus ();

  fht_control #(.A_BIT(AB), .LAT(LT)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endfunction

  function automatic int brev(int v);
    int r = 0;
    for (int i = 0; i < AB; i++) r |= ((v >> i) & 1) << (AB - 1 - i);
    return r;
  endfunction

  // Reference addressing for read slot c of stage s, straight from the sector rules.
  function automatic void ref_addr(input int s, input int c,
                                   output int rd, output int bias, output int sec,
                                   output int p2, output int coef);
    int l, off;
    if (s == 0) begin
      rd = brev(c); bias = rd; sec = 0; p2 = 0; coef = 0;
    end else begin
      l    = 1 << s;
      off  = c % l;
      rd   = c;
      sec  = c / l;
      bias = sec * l + (l - off) % l;
      p2   = (off >= l / 2) ? 1 : 0;
      coef = (off % (l / 2)) * (1 << (AB - s));
    end
  endfunction

  function automatic exp_t idle_e();
    exp_t e = '{default: 0};
    e.idle = 1;
    return e;
  endfunction

  function automatic exp_t run_e(int k);
    exp_t e = '{default: 0};
    int s = k / SL;
    int c = k % SL;
    int d1, d2, d3;
    e.stg      = s;
    e.st_zero  = (s == 0);
    e.st_last  = (s == AB);
    e.src_data = (s % 2 == 1);
    e.rd_ph    = (c < D);
    if (e.rd_ph) ref_addr(s, c, e.rd, e.bias, e.sec, e.p2, e.coef);
    if (c >= LT) begin
      e.we   = 1;
      e.we_a = e.src_data;
      e.we_b = !e.src_data;
      ref_addr(s, c - LT, e.wr, e.wrb, d1, d2, d3);
    end
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdy",      int'(bus.oRDY),         e.idle ? 1 : 0);
        chk("src_cont", int'(bus.oSOURCE_CONT), e.idle ? 0 : 1);
        chk("st_zero",  int'(bus.oST_ZERO),     int'(e.st_zero));
        chk("st_last",  int'(bus.oST_LAST),     int'(e.st_last));
        chk("src_data", int'(bus.oSOURCE_DATA), int'(e.src_data));
        chk("we_a",     int'(bus.oWE_A),        int'(e.we_a));
        chk("we_b",     int'(bus.oWE_B),        int'(e.we_b));
        if (!e.idle) chk("stage", int'(dut.stage), e.stg);
        if (e.idle || e.rd_ph) begin
          chk("addr_rd_0", int'(bus.oADDR_RD_0), e.rd);
          chk("addr_rd_1", int'(bus.oADDR_RD_1), e.rd);
          chk("addr_rd_2", int'(bus.oADDR_RD_2), e.bias);
          chk("addr_rd_3", int'(bus.oADDR_RD_3), e.bias);
          chk("sector",    int'(bus.oSECTOR),    e.sec);
          chk("part2",     int'(bus.o2ND_PART_SUBSEC), e.p2);
          chk("coef",      int'(bus.oADDR_COEF), e.coef);
        end
        if (e.idle || e.we) begin
          chk("addr_wr",      int'(bus.oADDR_WR),      e.wr);
          chk("addr_wr_bias", int'(bus.oADDR_WR_BIAS), e.wrb);
        end
      end
    end
  end

  task automatic wait_drain(input int lim);
    int n = 0;
    while (q.size() > 0 && n < lim) begin
      @(posedge iCLK);
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Entry pushed first covers the clock before iSTART is sampled.
  task automatic start_run();
    @(posedge iCLK);
    #1;
    q.push_back(idle_e());
    bus.iSTART = 1'b1;
    for (int k = 0; k < RUN_CYC; k++) q.push_back(run_e(k));
    q.push_back(idle_e());
    q.push_back(idle_e());
    @(posedge iCLK);
    #1;
    bus.iSTART = 1'b0;
  endtask

  task automatic pulse_start_after(input int r);
    repeat (r) @(posedge iCLK);
    #1;
    bus.iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    bus.iSTART = 1'b0;
  endtask

  task automatic abort_after(input int r);
    repeat (r) @(posedge iCLK);
    #1;
    iRESET = 1'b1;
    q.delete();
    repeat (3) q.push_back(idle_e());
    @(posedge iCLK);
    @(posedge iCLK);
    #1;
    iRESET = 1'b0;
  endtask

  initial begin : stimulus
    bus.iSTART = 1'b0;
    iRESET     = 1'b1;
    repeat (3) q.push_back(idle_e());
    @(posedge iCLK);
    @(posedge iCLK);
    #1;
    iRESET = 1'b0;
    wait_drain(10);

    repeat ($urandom_range(1, 5)) @(posedge iCLK);
    start_run();
    wait_drain(RUN_CYC + 20);

    repeat ($urandom_range(1, 8)) @(posedge iCLK);
    start_run();
    pulse_start_after($urandom_range(20, 400));
    pulse_start_after($urandom_range(1, 40));
    wait_drain(RUN_CYC + 20);

    start_run();
    abort_after($urandom_range(70, 460));
    wait_drain(10);

    start_run();
    wait_drain(RUN_CYC + 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

endmodule
